// File: rtl/operand_decode_stage.sv
// RV32I decode stage: register-file addressing, operand bypass with x0 masking,
// immediate generation, load-use stall and the ID/EX pipeline register.
module operand_decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [4:0]      rf_addr_a,
    output logic [4:0]      rf_addr_b,
    input  logic [XLEN-1:0] rf_data_a,
    input  logic [XLEN-1:0] rf_data_b,
    input  logic            fwd_ex_wr,
    input  logic            fwd_ex_is_load,
    input  logic [4:0]      fwd_ex_rd,
    input  logic [XLEN-1:0] fwd_ex_result,
    input  logic            fwd_mem_wr,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_result,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            de_valid,
    output logic [XLEN-1:0] de_pc,
    output logic [XLEN-1:0] de_rs1_val,
    output logic [XLEN-1:0] de_rs2_val,
    output logic [XLEN-1:0] de_imm,
    output logic [4:0]      de_rd,
    output logic [6:0]      de_opcode,
    output logic [2:0]      de_funct3,
    output logic            de_funct7b5,
    output logic            de_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2;
    logic            rs1_used, rs2_used;
    logic            hazard;
    logic            illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [4:0]      rd;

    logic            de_valid_q, de_valid_d;
    logic [XLEN-1:0] de_pc_q, de_pc_d;
    logic [XLEN-1:0] de_rs1_val_q, de_rs1_val_d;
    logic [XLEN-1:0] de_rs2_val_q, de_rs2_val_d;
    logic [XLEN-1:0] de_imm_q, de_imm_d;
    logic [4:0]      de_rd_q, de_rd_d;
    logic [6:0]      de_opcode_q, de_opcode_d;
    logic [2:0]      de_funct3_q, de_funct3_d;
    logic            de_funct7b5_q, de_funct7b5_d;
    logic            de_illegal_q, de_illegal_d;

    // The register file does not hardwire x0, so address 0 is masked here first.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_wr,
        input logic            ex_ld,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_val,
        input logic            mem_wr,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_val
    );
        if (addr == 5'd0)                          return '0;
        else if (ex_wr && !ex_ld && ex_rd == addr) return ex_val;
        else if (mem_wr && mem_rd == addr)         return mem_val;
        else                                       return rf_val;
    endfunction

    assign opcode    = if_instr[6:0];
    assign rs1       = if_instr[19:15];
    assign rs2       = if_instr[24:20];
    assign rf_addr_a = rs1;
    assign rf_addr_b = rs2;

    always_comb begin
        rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        rs2_used = (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
        hazard   = if_valid && fwd_ex_wr && fwd_ex_is_load && (fwd_ex_rd != 5'd0) &&
                   ((rs1_used && rs1 == fwd_ex_rd) || (rs2_used && rs2 == fwd_ex_rd));
        // A flushed slot is discarded anyway, so never stall against it.
        id_ready = flush ? 1'b1 : (ex_ready && !hazard);
    end

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            OP_STORE:  imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH: imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                                if_instr[30:25], if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {if_instr[31:12], 12'b0};
            OP_JAL:    imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                                if_instr[20], if_instr[30:21], 1'b0};
            default:   imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP, OP_MISC, OP_SYSTEM: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
        rd      = (opcode == OP_STORE || opcode == OP_BRANCH) ? 5'd0 : if_instr[11:7];
        rs1_val = resolve(rs1, rf_data_a, fwd_ex_wr, fwd_ex_is_load, fwd_ex_rd,
                          fwd_ex_result, fwd_mem_wr, fwd_mem_rd, fwd_mem_result);
        rs2_val = resolve(rs2, rf_data_b, fwd_ex_wr, fwd_ex_is_load, fwd_ex_rd,
                          fwd_ex_result, fwd_mem_wr, fwd_mem_rd, fwd_mem_result);
    end

    always_comb begin
        de_valid_d    = de_valid_q;
        de_pc_d       = de_pc_q;
        de_rs1_val_d  = de_rs1_val_q;
        de_rs2_val_d  = de_rs2_val_q;
        de_imm_d      = de_imm_q;
        de_rd_d       = de_rd_q;
        de_opcode_d   = de_opcode_q;
        de_funct3_d   = de_funct3_q;
        de_funct7b5_d = de_funct7b5_q;
        de_illegal_d  = de_illegal_q;
        if (flush || (ex_ready && hazard)) begin
            de_valid_d   = 1'b0;
            de_illegal_d = 1'b0;
        end else if (ex_ready) begin
            de_valid_d    = if_valid;
            de_pc_d       = if_pc;
            de_rs1_val_d  = rs1_val;
            de_rs2_val_d  = rs2_val;
            de_imm_d      = imm;
            de_rd_d       = rd;
            de_opcode_d   = opcode;
            de_funct3_d   = if_instr[14:12];
            de_funct7b5_d = if_instr[30];
            de_illegal_d  = if_valid && illegal;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_valid_q    <= 1'b0;
            de_pc_q       <= RESET_PC;
            de_rs1_val_q  <= '0;
            de_rs2_val_q  <= '0;
            de_imm_q      <= '0;
            de_rd_q       <= '0;
            de_opcode_q   <= '0;
            de_funct3_q   <= '0;
            de_funct7b5_q <= 1'b0;
            de_illegal_q  <= 1'b0;
        end else begin
            de_valid_q    <= de_valid_d;
            de_pc_q       <= de_pc_d;
            de_rs1_val_q  <= de_rs1_val_d;
            de_rs2_val_q  <= de_rs2_val_d;
            de_imm_q      <= de_imm_d;
            de_rd_q       <= de_rd_d;
            de_opcode_q   <= de_opcode_d;
            de_funct3_q   <= de_funct3_d;
            de_funct7b5_q <= de_funct7b5_d;
            de_illegal_q  <= de_illegal_d;
        end
    end

    assign de_valid    = de_valid_q;
    assign de_pc       = de_pc_q;
    assign de_rs1_val  = de_rs1_val_q;
    assign de_rs2_val  = de_rs2_val_q;
    assign de_imm      = de_imm_q;
    assign de_rd       = de_rd_q;
    assign de_opcode   = de_opcode_q;
    assign de_funct3   = de_funct3_q;
    assign de_funct7b5 = de_funct7b5_q;
    assign de_illegal  = de_illegal_q;

endmodule

// File: tb/tb_operand_decode_stage.sv
// Directed bench for operand_decode_stage: inputs change on negedge, outputs
// are checked at negedge (combinational) or #1 after posedge (registered).
module tb_operand_decode_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        id_ready;
    logic [4:0]  rf_addr_a, rf_addr_b;
    logic [31:0] rf_data_a, rf_data_b;
    logic        fwd_ex_wr, fwd_ex_is_load;
    logic [4:0]  fwd_ex_rd;
    logic [31:0] fwd_ex_result;
    logic        fwd_mem_wr;
    logic [4:0]  fwd_mem_rd;
    logic [31:0] fwd_mem_result;
    logic        flush, ex_ready;
    logic        de_valid;
    logic [31:0] de_pc, de_rs1_val, de_rs2_val, de_imm;
    logic [4:0]  de_rd;
    logic [6:0]  de_opcode;
    logic [2:0]  de_funct3;
    logic        de_funct7b5, de_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .fwd_ex_wr(fwd_ex_wr), .fwd_ex_is_load(fwd_ex_is_load), .fwd_ex_rd(fwd_ex_rd),
        .fwd_ex_result(fwd_ex_result), .fwd_mem_wr(fwd_mem_wr), .fwd_mem_rd(fwd_mem_rd),
        .fwd_mem_result(fwd_mem_result), .flush(flush), .ex_ready(ex_ready),
        .de_valid(de_valid), .de_pc(de_pc), .de_rs1_val(de_rs1_val), .de_rs2_val(de_rs2_val),
        .de_imm(de_imm), .de_rd(de_rd), .de_opcode(de_opcode), .de_funct3(de_funct3),
        .de_funct7b5(de_funct7b5), .de_illegal(de_illegal)
    );

    task automatic idle();
        if_valid = 0; if_instr = 32'h0000_0013; if_pc = 0;
        rf_data_a = 0; rf_data_b = 0;
        fwd_ex_wr = 0; fwd_ex_is_load = 0; fwd_ex_rd = 0; fwd_ex_result = 0;
        fwd_mem_wr = 0; fwd_mem_rd = 0; fwd_mem_result = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 0; idle();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (de_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h exp 0", de_valid); end
        n_checks++; if (de_pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %0h exp %0h", de_pc, RST_PC); end
        n_checks++; if ({de_rs1_val, de_rs2_val, de_imm, de_rd, de_opcode, de_funct3, de_funct7b5, de_illegal} !== '0) begin
            n_fail++; $display("FAIL reset_fields got nonzero imm=%0h rd=%0h op=%0h", de_imm, de_rd, de_opcode); end
        @(negedge clk); reset = 1;
    endtask

    task automatic test_addi();
        @(negedge clk); idle();
        if_valid = 1; if_instr = 32'hFFF0_0293; if_pc = 32'h100; rf_data_a = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (rf_addr_a !== 5'd0) begin n_fail++; $display("FAIL addi_addr_a got %0d exp 0", rf_addr_a); end
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready got %0h exp 1", id_ready); end
        tick();
        n_checks++; if (de_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0h exp 1", de_valid); end
        n_checks++; if (de_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_imm got %0h exp ffffffff", de_imm); end
        n_checks++; if (de_rs1_val !== 32'h0) begin n_fail++; $display("FAIL addi_x0 got %0h exp 0", de_rs1_val); end
        n_checks++; if (de_rd !== 5'd5) begin n_fail++; $display("FAIL addi_rd got %0d exp 5", de_rd); end
        n_checks++; if (de_pc !== 32'h100 || de_opcode !== 7'h13 || de_illegal !== 1'b0) begin
            n_fail++; $display("FAIL addi_pc_op got pc=%0h op=%0h ill=%0h exp 100/13/0", de_pc, de_opcode, de_illegal); end
    endtask

    task automatic test_forwarding();
        // ADD x3,x1,x2: EX and MEM both write x1, EX must win
        @(negedge clk); idle();
        if_valid = 1; if_instr = 32'h0020_81B3; if_pc = 32'h104;
        rf_data_a = 10; rf_data_b = 20;
        fwd_ex_wr = 1; fwd_ex_rd = 1; fwd_ex_result = 32'h55;
        fwd_mem_wr = 1; fwd_mem_rd = 1; fwd_mem_result = 32'h66;
        #1;
        n_checks++; if (rf_addr_b !== 5'd2) begin n_fail++; $display("FAIL add_addr_b got %0d exp 2", rf_addr_b); end
        tick();
        n_checks++; if (de_rs1_val !== 32'h55) begin n_fail++; $display("FAIL fwd_ex_prio got %0h exp 55", de_rs1_val); end
        n_checks++; if (de_rs2_val !== 32'd20) begin n_fail++; $display("FAIL fwd_rf_b got %0h exp 14", de_rs2_val); end
        // MEM-only forward on x2; EX is a non-matching load
        @(negedge clk);
        fwd_ex_is_load = 1; fwd_ex_rd = 9;
        fwd_mem_rd = 2; fwd_mem_result = 32'h77;
        tick();
        n_checks++; if (de_rs2_val !== 32'h77 || de_rs1_val !== 32'd10) begin
            n_fail++; $display("FAIL fwd_mem got a=%0h b=%0h exp a/77", de_rs1_val, de_rs2_val); end
    endtask

    task automatic test_load_use();
        // SW x4,8(x2) behind a load to x4
        @(negedge clk); idle();
        if_valid = 1; if_instr = 32'h0041_2423; if_pc = 32'h108;
        fwd_ex_wr = 1; fwd_ex_is_load = 1; fwd_ex_rd = 4;
        #1;
        n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready got %0h exp 0", id_ready); end
        tick();
        n_checks++; if (de_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %0h exp 0", de_valid); end
        @(negedge clk); fwd_ex_wr = 0; fwd_ex_is_load = 0;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release got %0h exp 1", id_ready); end
        tick();
        n_checks++; if (de_valid !== 1'b1 || de_imm !== 32'd8 || de_rd !== 5'd0 || de_pc !== 32'h108) begin
            n_fail++; $display("FAIL sw_capture got v=%0h imm=%0h rd=%0d pc=%0h exp 1/8/0/108", de_valid, de_imm, de_rd, de_pc); end
    endtask

    task automatic test_flush_hazard();
        @(negedge clk); idle();
        if_valid = 1; if_instr = 32'h0041_2423; if_pc = 32'h10C;
        fwd_ex_wr = 1; fwd_ex_is_load = 1; fwd_ex_rd = 4; flush = 1;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %0h exp 1", id_ready); end
        tick();
        n_checks++; if (de_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0h exp 0", de_valid); end
    endtask

    task automatic test_stall();
        @(negedge clk); idle();
        if_valid = 1; if_instr = 32'hFFF0_0293; if_pc = 32'h200;
        tick();
        @(negedge clk);
        ex_ready = 0; if_instr = 32'h0020_81B3; if_pc = 32'h300; rf_data_a = 1; rf_data_b = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %0h exp 0", i, id_ready); end
            tick();
            n_checks++; if (de_valid !== 1'b1 || de_pc !== 32'h200 || de_imm !== 32'hFFFF_FFFF ||
                            de_rd !== 5'd5 || de_opcode !== 7'h13 || de_rs2_val !== 32'h0) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v=%0h pc=%0h imm=%0h rd=%0d op=%0h", i, de_valid, de_pc, de_imm, de_rd, de_opcode); end
        end
        @(negedge clk); ex_ready = 1;
        tick();
        n_checks++; if (de_pc !== 32'h300 || de_rs1_val !== 32'd1 || de_funct7b5 !== 1'b0) begin
            n_fail++; $display("FAIL stall_resume got pc=%0h a=%0h exp 300/1", de_pc, de_rs1_val); end
    endtask

    task automatic test_imm_and_illegal();
        // JAL x1,-4 while EX loads the rs1-field register: JAL reads no sources
        @(negedge clk); idle();
        if_valid = 1; if_instr = 32'hFFDF_F0EF; if_pc = 32'h400;
        fwd_ex_wr = 1; fwd_ex_is_load = 1; fwd_ex_rd = 5'd31;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL jal_nohaz got %0h exp 1", id_ready); end
        fwd_ex_rd = 5'd1; #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL jal_nohaz_x1 got %0h exp 1", id_ready); end
        tick();
        n_checks++; if (de_imm !== 32'hFFFF_FFFC || de_rd !== 5'd1 || de_valid !== 1'b1) begin
            n_fail++; $display("FAIL jal_imm got imm=%0h rd=%0d v=%0h exp fffffffc/1/1", de_imm, de_rd, de_valid); end
        // ADDI x5,x0,-1 with EX loading x0 must not stall
        @(negedge clk); if_instr = 32'hFFF0_0293; fwd_ex_rd = 5'd0; #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL x0_load_nohaz got %0h exp 1", id_ready); end
        // LUI x7,0x12345; rs1 field = x8 is being loaded but unused
        @(negedge clk); if_instr = 32'h1234_53B7; fwd_ex_rd = 5'd8; #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lui_nohaz got %0h exp 1", id_ready); end
        tick();
        n_checks++; if (de_imm !== 32'h1234_5000 || de_rd !== 5'd7) begin
            n_fail++; $display("FAIL lui_imm got %0h rd=%0d exp 12345000/7", de_imm, de_rd); end
        // BNE x1,x2,+16
        @(negedge clk); idle(); if_valid = 1; if_instr = 32'h0020_9863;
        tick();
        n_checks++; if (de_imm !== 32'd16 || de_rd !== 5'd0 || de_funct3 !== 3'd1) begin
            n_fail++; $display("FAIL bne_imm got %0h rd=%0d f3=%0d exp 10/0/1", de_imm, de_rd, de_funct3); end
        // Reserved opcode
        @(negedge clk); if_instr = 32'h0000_007F;
        tick();
        n_checks++; if (de_illegal !== 1'b1 || de_valid !== 1'b1 || de_imm !== 32'h0) begin
            n_fail++; $display("FAIL illegal got ill=%0h v=%0h imm=%0h exp 1/1/0", de_illegal, de_valid, de_imm); end
        @(negedge clk); flush = 1;
        tick();
        n_checks++; if (de_illegal !== 1'b0 || de_valid !== 1'b0) begin
            n_fail++; $display("FAIL illegal_clear got ill=%0h v=%0h exp 0/0", de_illegal, de_valid); end
        // Invalid slot with bad opcode is not flagged
        @(negedge clk); flush = 0; if_valid = 0; if_instr = 32'h0000_007F; if_pc = 32'h44;
        tick();
        n_checks++; if (de_illegal !== 1'b0 || de_valid !== 1'b0 || de_pc !== 32'h44) begin
            n_fail++; $display("FAIL invalid_slot got ill=%0h v=%0h pc=%0h exp 0/0/44", de_illegal, de_valid, de_pc); end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk); idle();
        if_valid = 1; if_instr = 32'hFFF0_0293; if_pc = 32'h500;
        tick();
        @(negedge clk); if_instr = 32'h0041_2423; fwd_ex_wr = 1; fwd_ex_is_load = 1; fwd_ex_rd = 4;
        tick();
        #2 reset = 0;
        #1;
        n_checks++; if (de_pc !== RST_PC || de_rd !== 5'd0 || de_imm !== 32'h0 || de_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got pc=%0h rd=%0d imm=%0h exp %0h/0/0", de_pc, de_rd, de_imm, RST_PC); end
        n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0h exp 0", id_ready); end
        @(negedge clk); reset = 1; idle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_forwarding();
        test_load_use();
        test_flush_hazard();
        test_stall();
        test_imm_and_illegal();
        test_reset_mid_stall();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
